swarm_config_regs: RTL and testbench

Host-facing AXI-Lite register responder on the OCL path, and the read side of the `swarm` configuration package. Software uses it to discover the build's compile-time configuration and to drive a small set of runtime controls. It sits between the OCL AXI-Lite crossbar port and the tile logic. It returns package constants as read-only registers and exports writable control fields plus a free-running 64-bit cycle counter with an atomic high-word snapshot.

---
 rtl/swarm_config_regs.sv | 210 +++++++++++++++++++++
 tb/tb_swarm_config_regs.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swarm_config_regs.sv
// Host-visible configuration and control registers on the OCL AXI-Lite port.
// Latency: 1 cycle for both writes (bvalid) and reads (rvalid).
// Backpressure: one outstanding write and one outstanding read; a held response stalls its own channel.

package swarm;
    localparam int          N_TILES           = 4;
    localparam logic [31:0] VERSION           = 32'h5357_0102;
    localparam int          LOG_TQ_SIZE       = 10;
    localparam int          LOG_CQ_SLICE_SIZE = 8;
    localparam int          TS_WIDTH          = 32;
    localparam int          N_THREADS         = 16;
    localparam bit          UNORDERED         = 1'b0;
    localparam bit          NON_SPEC          = 1'b1;
    localparam bit          NO_SPILLING       = 1'b0;
    localparam bit          ALL_OCL           = 1'b1;
    localparam logic [4:0]  LOG_GVT_PERIOD    = 5'd12;
endpackage

module swarm_config_regs #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          N_TILES    = swarm::N_TILES,
    parameter logic [31:0] VERSION    = swarm::VERSION
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic [N_TILES-1:0]    cfg_tile_en,
    output logic [4:0]            cfg_log_gvt_period,
    output logic                  start_pulse,
    output logic                  running
);

    localparam int WW = ADDR_WIDTH - 2;

    // Word indices of the register map (byte address >> 2).
    localparam logic [WW-1:0] R_ID      = WW'(0);
    localparam logic [WW-1:0] R_NTILES  = WW'(1);
    localparam logic [WW-1:0] R_PARAMS  = WW'(2);
    localparam logic [WW-1:0] R_FLAGS   = WW'(3);
    localparam logic [WW-1:0] R_SCRATCH = WW'(4);
    localparam logic [WW-1:0] R_TILE_EN = WW'(5);
    localparam logic [WW-1:0] R_CTRL    = WW'(6);
    localparam logic [WW-1:0] R_GVT     = WW'(7);
    localparam logic [WW-1:0] R_CYC_LO  = WW'(8);
    localparam logic [WW-1:0] R_CYC_HI  = WW'(9);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] PARAMS_WORD = {8'(swarm::N_THREADS), 8'(swarm::TS_WIDTH),
                                           8'(swarm::LOG_CQ_SLICE_SIZE), 8'(swarm::LOG_TQ_SIZE)};
    localparam logic [31:0] FLAGS_WORD  = {28'b0, swarm::ALL_OCL, swarm::NO_SPILLING,
                                           swarm::NON_SPEC, swarm::UNORDERED};

    logic [31:0]        scratch;
    logic [N_TILES-1:0] tile_en;
    logic [N_TILES-1:0] tile_en_next;
    logic [4:0]         gvt;
    logic [63:0]        cycle_cnt;
    logic [31:0]        shadow;

    logic [WW-1:0]      wr_idx;
    logic [WW-1:0]      rd_idx;
    logic               wr_fire;
    logic               rd_fire;
    logic               wr_mapped;
    logic [31:0]        rd_dat;
    logic               rd_err;
    logic               unused_addr_lsbs;

    // Byte-offset bits carry no meaning: every register is a full word.
    assign wr_idx           = awaddr[ADDR_WIDTH-1:2];
    assign rd_idx           = araddr[ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    // AW and W are only taken together, and only when no write response is pending.
    assign wr_fire = awvalid & wvalid & ~bvalid & ~rst;
    assign awready = wr_fire;
    assign wready  = wr_fire;
    assign rd_fire = arvalid & ~rvalid & ~rst;
    assign arready = ~rvalid & ~rst;

    assign cfg_tile_en        = tile_en;
    assign cfg_log_gvt_period = gvt;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Write decode: which addresses exist, and the strobe-merged tile-enable value.
    always_comb begin
        wr_mapped = 1'b0;
        case (wr_idx)
            R_ID, R_NTILES, R_PARAMS, R_FLAGS, R_SCRATCH,
            R_TILE_EN, R_CTRL, R_GVT, R_CYC_LO, R_CYC_HI: wr_mapped = 1'b1;
            default:                                     wr_mapped = 1'b0;
        endcase
        tile_en_next = tile_en;
        for (int i = 0; i < N_TILES; i++) begin
            if (wstrb[i/8]) tile_en_next[i] = wdata[i];
        end
    end

    // Read mux: values as they stand in the accept cycle (pre-write on a concurrent write).
    always_comb begin
        rd_dat = '0;
        rd_err = 1'b0;
        case (rd_idx)
            R_ID:      rd_dat = VERSION;
            R_NTILES:  rd_dat = 32'(N_TILES);
            R_PARAMS:  rd_dat = PARAMS_WORD;
            R_FLAGS:   rd_dat = FLAGS_WORD;
            R_SCRATCH: rd_dat = scratch;
            R_TILE_EN: rd_dat[N_TILES-1:0] = tile_en;
            R_CTRL:    rd_dat[0] = running;
            R_GVT:     rd_dat[4:0] = gvt;
            R_CYC_LO:  rd_dat = cycle_cnt[31:0];
            R_CYC_HI:  rd_dat = shadow;
            default:   rd_err = 1'b1;
        endcase
    end

    // Write channel: register updates, run control and the write response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid      <= 1'b0;
            bresp       <= RESP_OKAY;
            scratch     <= '0;
            tile_en     <= '0;
            gvt         <= swarm::LOG_GVT_PERIOD;
            running     <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (wr_fire) begin
                bvalid <= 1'b1;
                bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                case (wr_idx)
                    R_SCRATCH: scratch <= merge_bytes(scratch, wdata, wstrb);
                    R_TILE_EN: tile_en <= tile_en_next;
                    R_GVT:     if (wstrb[0]) gvt <= wdata[4:0];
                    R_CTRL: begin
                        // Stop dominates; start only pulses on a real 0->1 transition.
                        if (wstrb[0]) begin
                            if (wdata[1]) begin
                                running <= 1'b0;
                            end else if (wdata[0] && !running) begin
                                running     <= 1'b1;
                                start_pulse <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end else if (bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read channel: registered data/response, held stable until rready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
            shadow <= '0;
        end else begin
            if (rd_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_dat;
                rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                // Snapshot the high word in the same cycle the low word is sampled.
                if (rd_idx == R_CYC_LO) shadow <= cycle_cnt[63:32];
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Free-running cycle counter, wraps naturally at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_cnt <= '0;
        else     cycle_cnt <= cycle_cnt + 64'd1;
    end

endmodule

// File: tb/tb_swarm_config_regs.sv
// Self-checking bench for swarm_config_regs: directed cases plus randomized traffic
// compared against a register-map model that tracks the counter from elapsed cycles.
// Responses are sampled on the falling edge; inputs change on the falling edge.

module tb_swarm_config_regs;

    localparam int          NT        = swarm::N_TILES;
    localparam logic [31:0] TILE_MASK = 32'((64'd1 << NT) - 64'd1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, start_pulse, running;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [NT-1:0] cfg_tile_en;
    logic [4:0]  cfg_log_gvt_period;

    swarm_config_regs #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .cfg_tile_en(cfg_tile_en), .cfg_log_gvt_period(cfg_log_gvt_period),
        .start_pulse(start_pulse), .running(running)
    );

    always #5 clk = ~clk;

    logic [63:0] tb_cyc = '0;
    always @(posedge clk) tb_cyc <= tb_cyc + 64'd1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state. The counter is derived from elapsed clocks since a known anchor.
    logic [31:0] m_scratch, m_tile, m_shadow;
    logic        m_running;
    logic [4:0]  m_gvt;
    logic [63:0] cyc_base, cyc_ref;

    function automatic logic [63:0] model_cyc();
        return cyc_base + (tb_cyc - cyc_ref);
    endfunction

    task automatic model_reset();
        m_scratch = '0; m_tile = '0; m_shadow = '0; m_running = 1'b0;
        m_gvt = swarm::LOG_GVT_PERIOD;
        cyc_base = '0; cyc_ref = tb_cyc;
    endtask

    task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        logic [63:0] c;
        c = model_cyc();
        d = '0;
        r = 2'b00;
        case (int'(a >> 2))
            0: d = swarm::VERSION;
            1: d = 32'(NT);
            2: d = 32'(swarm::LOG_TQ_SIZE + swarm::LOG_CQ_SLICE_SIZE * 256 +
                       swarm::TS_WIDTH * 65536 + swarm::N_THREADS * 16777216);
            3: d = 32'(int'(swarm::UNORDERED) + 2 * int'(swarm::NON_SPEC) +
                       4 * int'(swarm::NO_SPILLING) + 8 * int'(swarm::ALL_OCL));
            4: d = m_scratch;
            5: d = m_tile;
            6: d = {31'b0, m_running};
            7: d = {27'b0, m_gvt};
            8: begin d = c[31:0]; m_shadow = c[63:32]; end
            9: d = m_shadow;
            default: r = 2'b10;
        endcase
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic pulse, output logic [1:0] r);
        logic [31:0] mask;
        mask  = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        pulse = 1'b0;
        r     = 2'b00;
        case (int'(a >> 2))
            0, 1, 2, 3, 8, 9: ;
            4: m_scratch = (m_scratch & ~mask) | (d & mask);
            5: m_tile = ((m_tile & ~mask) | (d & mask)) & TILE_MASK;
            6: if (s[0]) begin
                   if (d[1]) m_running = 1'b0;
                   else if (d[0] && !m_running) begin m_running = 1'b1; pulse = 1'b1; end
               end
            7: if (s[0]) m_gvt = d[4:0];
            default: r = 2'b10;
        endcase
    endtask

    logic [31:0] got;

    // One write and/or read, launched together; checks handshake, response and outputs.
    task automatic do_txn(input bit wr, input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                          input bit rd, input logic [7:0] ra, output logic [31:0] rd_got);
        logic [31:0] exp_d;
        logic [1:0]  exp_rr, exp_br;
        logic        exp_pulse;
        exp_d = '0; exp_rr = '0; exp_br = '0; exp_pulse = 1'b0;
        @(negedge clk);
        awvalid = wr; wvalid = wr; awaddr = wa; wdata = wd; wstrb = ws;
        arvalid = rd; araddr = ra;
        if (rd) model_read(ra, exp_d, exp_rr);
        if (wr) model_write(wa, wd, ws, exp_pulse, exp_br);
        #1;
        if (wr) check_eq("awready", 64'(awready & wready), 64'd1);
        if (rd) check_eq("arready", 64'(arready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        if (wr) begin
            check_eq("bvalid", 64'(bvalid), 64'd1);
            check_eq("bresp", 64'(bresp), 64'(exp_br));
        end
        if (rd) begin
            check_eq("rvalid", 64'(rvalid), 64'd1);
            check_eq("rdata", 64'(rdata), 64'(exp_d));
            check_eq("rresp", 64'(rresp), 64'(exp_rr));
        end
        check_eq("start_pulse", 64'(start_pulse), 64'(exp_pulse));
        check_eq("running", 64'(running), 64'(m_running));
        check_eq("tile_en", 64'(cfg_tile_en), 64'(m_tile[NT-1:0]));
        check_eq("gvt", 64'(cfg_log_gvt_period), 64'(m_gvt));
        rd_got = rdata;
        @(negedge clk);
        check_eq("pulse_1cyc", 64'(start_pulse), 64'd0);
        if (wr) check_eq("bvalid_clr", 64'(bvalid), 64'd0);
        if (rd) check_eq("rvalid_clr", 64'(rvalid), 64'd0);
    endtask

    task automatic wr_txn(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        do_txn(1'b1, a, d, s, 1'b0, 8'h00, dummy);
    endtask

    task automatic rd_txn(input logic [7:0] a, output logic [31:0] d);
        do_txn(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, a, d);
    endtask

    task automatic force_counter(input logic [63:0] v);
        @(negedge clk);
        force dut.cycle_cnt = v;
        #1;
        release dut.cycle_cnt;
        cyc_base = v;
        cyc_ref  = tb_cyc;
    endtask

    initial begin
        logic [31:0] exp_d, lo;
        logic [1:0]  exp_r;
        logic        pulse;
        logic [1:0]  br;

        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_awready", 64'(awready), 64'd0);
        check_eq("rst_arready", 64'(arready), 64'd0);
        check_eq("rst_bvalid", 64'(bvalid), 64'd0);
        check_eq("rst_rvalid", 64'(rvalid), 64'd0);
        check_eq("rst_rdata", 64'(rdata), 64'd0);
        check_eq("rst_tile", 64'(cfg_tile_en), 64'd0);
        check_eq("rst_gvt", 64'(cfg_log_gvt_period), 64'(swarm::LOG_GVT_PERIOD));
        check_eq("rst_running", 64'({start_pulse, running}), 64'd0);
        rst = 1'b0;
        model_reset();

        // Identity registers.
        rd_txn(8'h00, got);
        check_eq("id_lit", 64'(got), 64'(swarm::VERSION));
        rd_txn(8'h04, got);
        rd_txn(8'h08, got);
        rd_txn(8'h0C, got);

        // Byte strobes, tile enables, ignored address LSBs.
        wr_txn(8'h10, 32'hAABBCCDD, 4'b0101);
        rd_txn(8'h10, got);
        check_eq("scratch_strb", 64'(got), 64'h00BB00DD);
        wr_txn(8'h14, 32'hFFFFFFFF, 4'hF);
        rd_txn(8'h17, got);
        check_eq("tile_read", 64'(got), 64'(TILE_MASK));

        // Run control.
        wr_txn(8'h18, 32'd1, 4'hF);
        wr_txn(8'h18, 32'd1, 4'hF);
        wr_txn(8'h18, 32'd2, 4'hF);
        wr_txn(8'h18, 32'd3, 4'hF);
        rd_txn(8'h18, got);

        // Errors and writes to read-only registers.
        rd_txn(8'h40, got);
        wr_txn(8'h40, 32'h12345678, 4'hF);
        wr_txn(8'h00, 32'h12345678, 4'hF);

        // Read backpressure: response held, no new address accepted.
        @(negedge clk);
        rready = 1'b0;
        model_read(8'h10, exp_d, exp_r);
        arvalid = 1'b1; araddr = 8'h10;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            arvalid = 1'b1; araddr = 8'h00;
            #1;
            check_eq("rhold_valid", 64'(rvalid), 64'd1);
            check_eq("rhold_data", 64'(rdata), 64'(exp_d));
            check_eq("rhold_arready", 64'(arready), 64'd0);
            @(negedge clk);
        end
        arvalid = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        check_eq("rhold_release", 64'(rvalid), 64'd0);

        // Write backpressure: second write must wait while bvalid is held.
        @(negedge clk);
        bready = 1'b0;
        model_write(8'h10, 32'h0BADF00D, 4'hF, pulse, br);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 8'h10; wdata = 32'h0BADF00D; wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        wdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bhold_valid", 64'(bvalid), 64'd1);
            check_eq("bhold_awready", 64'(awready), 64'd0);
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        check_eq("bhold_release", 64'(bvalid), 64'd0);
        rd_txn(8'h10, got);

        // Concurrent read and write to GVT: read sees the old value.
        do_txn(1'b1, 8'h1C, 32'h00000003, 4'hF, 1'b1, 8'h1C, got);
        check_eq("concur_old", 64'(got), 64'(swarm::LOG_GVT_PERIOD));
        rd_txn(8'h1C, got);

        // Counter snapshot atomicity across the low-word carry.
        force_counter(64'h00000000_FFFFFFFE);
        rd_txn(8'h20, lo);
        check_eq("cyc_lo_ff", 64'(lo), 64'hFFFFFFFF);
        repeat (5) @(negedge clk);
        rd_txn(8'h24, got);
        check_eq("cyc_hi_snap", 64'(got), 64'd0);

        // Counter wrap through all-ones.
        force_counter(64'hFFFFFFFF_FFFFFFFE);
        rd_txn(8'h20, lo);
        rd_txn(8'h24, got);
        check_eq("wrap_hi_ones", 64'(got), 64'hFFFFFFFF);
        rd_txn(8'h20, lo);
        rd_txn(8'h24, got);
        check_eq("wrap_hi_zero", 64'(got), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            int kind, ia, ib;
            logic [7:0]  wa, ra;
            logic [31:0] wd;
            logic [3:0]  ws;
            kind = $urandom_range(0, 2);
            ia = $urandom_range(0, 11);
            ib = $urandom_range(0, 11);
            wa = (ia == 10) ? 8'h40 : (ia == 11) ? 8'hFC : 8'(ia * 4 + $urandom_range(0, 3));
            ra = (ib == 10) ? 8'h40 : (ib == 11) ? 8'hFC : 8'(ib * 4 + $urandom_range(0, 3));
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            if (ia == 6) begin
                ws = 4'hF;
                wd = 32'($urandom_range(0, 3));
            end
            do_txn(kind != 1, wa, wd, ws, kind != 0, ra, got);
        end

        // Reset while a read response is pending.
        wr_txn(8'h1C, 32'h00000007, 4'hF);
        wr_txn(8'h18, 32'd1, 4'hF);
        wr_txn(8'h14, 32'h00000005, 4'hF);
        @(negedge clk);
        arvalid = 1'b1; araddr = 8'h1C;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("pre_rst_rvalid", 64'(rvalid), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check_eq("mid_rst_gvt", 64'(cfg_log_gvt_period), 64'(swarm::LOG_GVT_PERIOD));
        check_eq("mid_rst_running", 64'(running), 64'd0);
        check_eq("mid_rst_tile", 64'(cfg_tile_en), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        rd_txn(8'h24, got);
        rd_txn(8'h1C, got);
        rd_txn(8'h20, got);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
